priority_demux_reg: RTL and testbench
=====================================

Name: priority_demux_reg

Overview:
- Inverse of the priority mux: one input stream fanned out to exactly one of CNT output channels, chosen by the highest-priority set bit of a per-beat select mask.
- Each output channel has a one-entry registered stage with valid/ready handshake, so a stalled channel never blocks beats bound for other channels.
- Used on the register-access fabric to steer one upstream request stream to per-block slave ports.

Parameters:
- WIDTH, 32, data width of each beat.
- CNT, 5, number of output channels (>=2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- din  input  WIDTH  input beat data.
- din_sel  input  CNT  destination mask; lowest set index wins (bit 0 highest priority).
- din_vld  input  1  input beat valid.
- din_rdy  output  1  input beat accepted when din_vld && din_rdy.
- dout  output  WIDTH*CNT  flattened outputs; channel c at dout[c*WIDTH +: WIDTH].
- dout_vld  output  CNT  per-channel valid.
- dout_rdy  input  CNT  per-channel ready from consumer.
- drop_pulse  output  1  one-cycle pulse when a beat with din_sel==0 is accepted and discarded.

Behaviour:
- Reset (clk edge with rst=1): all dout_vld=0, dout=0, drop_pulse=0. Clears any held beat mid-operation; no beat survives reset. rst has priority over every other event.
- Decode: tgt = index of lowest set bit of din_sel. Multiple set bits: only tgt receives the beat; other bits are ignored.
- Per channel c: full[c] = dout_vld[c]. Slot c can accept this cycle if !full[c] || dout_rdy[c] (pass-through on simultaneous drain).
- din_rdy (combinational): if din_sel==0, then 1. Otherwise it equals "slot tgt can accept".
- din_rdy depends on din_sel but not on din_vld. din_sel must be stable while din_vld=1 && !din_rdy.
- Accept, din_sel!=0: next cycle dout_vld[tgt]=1 and dout[tgt]=din. Latency is 1 cycle from acceptance to dout_vld.
- Accept, din_sel==0: beat discarded, no channel changes, drop_pulse=1 next cycle.
- Drain: when dout_vld[c] && dout_rdy[c] and no new beat is loaded into c, dout_vld[c] goes to 0 next cycle. dout[c] holds its last value (not cleared).
- Simultaneous drain and load on the same channel: dout_vld[c] stays 1 and dout[c] takes the new beat. Full throughput is 1 beat/cycle per channel.
- Channels are independent. A stalled channel c blocks only beats whose tgt==c. Beats to other channels proceed in the same cycle the blocked beat is replaced at the input.
- Ordering: beats to the same channel are delivered in acceptance order. No ordering guarantee across channels.
- dout[c] and dout_vld[c] are stable while dout_vld[c]=1 && !dout_rdy[c].
- No combinational path from dout_rdy to dout or dout_vld. din_rdy may depend combinationally on dout_rdy[tgt].

Optional Feature:
- Macro: PRIORITY_DEMUX_REG_DROP_CNT_EN.
- Defined: adds output drop_cnt [15:0]. It is reset to 0 and increments by 1 on each discarded beat, in the same cycle drop_pulse asserts.
- It saturates at 16'hFFFF (no wrap).
- It adds input drop_cnt_clr (1 bit), which sets drop_cnt to 0 next cycle. If a drop coincides with clear, the result is 1.
- Not defined: drop_cnt and drop_cnt_clr ports do not exist. drop_pulse behaviour is unchanged.

Test Plan:
- Reset mid-traffic: channels 0 and 2 full with 0xA5A5A5A5; assert rst 1 cycle -> all dout_vld=0, dout=0, and din_rdy=1 for any din_sel next cycle.
- Priority decode: din=0x11223344, din_sel=5'b10110, all ready -> next cycle dout_vld=5'b00010, dout[1]=0x11223344, no other channel valid.
- Back-pressure isolation: dout_rdy[3]=0 with channel 3 full; beat to ch3 -> din_rdy=0, held. Switch din_sel=5'b00001 -> accepted, dout_vld[0]=1 next cycle, ch3 beat unchanged.
- Streaming throughput: 8 back-to-back beats 0..7 to ch4, dout_rdy[4]=1 -> din_rdy stays 1, ch4 outputs 0..7 on consecutive cycles at 1-cycle latency.
- Drain/load same cycle: ch2 holding 0xDEAD, dout_rdy[2]=1, new beat 0xBEEF to ch2 -> dout_vld[2] stays 1 and dout[2]=0xBEEF next cycle, with exactly one handshake each side.
- Drop: din_sel=0, din_vld=1 for 3 cycles -> din_rdy=1 and three drop_pulse cycles, outputs unchanged. With PRIORITY_DEMUX_REG_DROP_CNT_EN: drop_cnt=3. Preload 16'hFFFE plus 3 drops -> drop_cnt=16'hFFFF.

Source files
------------

// File: rtl/priority_demux_reg.sv
// Priority demux: one beat stream steered to the lowest-indexed set bit of din_sel, one register stage per channel.
// Latency: 1 cycle from acceptance to dout_vld; 1 beat/cycle per channel with simultaneous drain and load.
// Backpressure: din_rdy follows only the target slot, so a stalled channel never blocks others. Optional macro: PRIORITY_DEMUX_REG_DROP_CNT_EN.
module priority_demux_reg #(
    parameter int WIDTH = 32,
    parameter int CNT   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic [CNT-1:0]       din_sel,
    input  logic                 din_vld,
    output logic                 din_rdy,
    output logic [WIDTH*CNT-1:0] dout,
    output logic [CNT-1:0]       dout_vld,
    input  logic [CNT-1:0]       dout_rdy,
    output logic                 drop_pulse
`ifdef PRIORITY_DEMUX_REG_DROP_CNT_EN
    ,
    output logic [15:0]          drop_cnt,
    input  logic                 drop_cnt_clr
`endif
);

    logic [CNT-1:0]            tgt_oh;
    logic [CNT-1:0]            can_acc;
    logic [CNT-1:0]            load;
    logic                      sel_nz;
    logic                      acc;
    logic                      drop_acc;
    logic [CNT-1:0][WIDTH-1:0] dat_q;
    logic [CNT-1:0]            vld_q;
    logic                      drop_q;

    // Isolate the lowest set bit: bit 0 has the highest priority.
    assign tgt_oh   = din_sel & (~din_sel + CNT'(1));
    assign sel_nz   = |din_sel;
    assign can_acc  = ~vld_q | dout_rdy;
    assign din_rdy  = sel_nz ? |(tgt_oh & can_acc) : 1'b1;
    assign acc      = din_vld & din_rdy;
    assign drop_acc = acc & ~sel_nz;
    assign load     = {CNT{acc}} & tgt_oh;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            dat_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_acc;
            for (int c = 0; c < CNT; c++) begin
                if (load[c]) begin
                    vld_q[c] <= 1'b1;
                    dat_q[c] <= din;
                end else if (dout_rdy[c]) begin
                    vld_q[c] <= 1'b0;
                end
            end
        end
    end

    assign dout       = dat_q;
    assign dout_vld   = vld_q;
    assign drop_pulse = drop_q;

`ifdef PRIORITY_DEMUX_REG_DROP_CNT_EN
    logic [15:0] cnt_q;

    // Clear wins over the old count but still records a coincident drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (drop_cnt_clr) begin
            cnt_q <= {15'd0, drop_acc};
        end else if (drop_acc && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign drop_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_priority_demux_reg.sv
// Self-checking bench for priority_demux_reg: directed steps then constrained-random traffic against a reference model.
module tb_priority_demux_reg;
    localparam int WIDTH = 32;
    localparam int CNT   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [WIDTH-1:0]     din;
    logic [CNT-1:0]       din_sel;
    logic                 din_vld;
    logic                 din_rdy;
    logic [WIDTH*CNT-1:0] dout;
    logic [CNT-1:0]       dout_vld;
    logic [CNT-1:0]       dout_rdy;
    logic                 drop_pulse;
    logic                 drop_cnt_clr;
`ifdef PRIORITY_DEMUX_REG_DROP_CNT_EN
    logic [15:0]          drop_cnt;
`endif

    always #5 clk = ~clk;

    priority_demux_reg #(.WIDTH(WIDTH), .CNT(CNT)) dut (
        .clk(clk), .rst(rst), .din(din), .din_sel(din_sel), .din_vld(din_vld),
        .din_rdy(din_rdy), .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .drop_pulse(drop_pulse)
`ifdef PRIORITY_DEMUX_REG_DROP_CNT_EN
        , .drop_cnt(drop_cnt), .drop_cnt_clr(drop_cnt_clr)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: what each channel holds, plus the drop bookkeeping.
    logic             exp_vld [CNT];
    logic [WIDTH-1:0] exp_dat [CNT];
    logic             exp_drop;
    int               exp_cnt;
    logic             last_rdy;

    function automatic int lowest(input logic [CNT-1:0] s);
        for (int i = 0; i < CNT; i++) if (s[i]) return i;
        return -1;
    endfunction

    function automatic logic model_rdy(input logic [CNT-1:0] s, input logic [CNT-1:0] r);
        int t;
        t = lowest(s);
        if (t < 0) return 1'b1;
        return !exp_vld[t] || r[t];
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < CNT; c++) begin
            chk($sformatf("vld%0d", c), WIDTH'(dout_vld[c]), WIDTH'(exp_vld[c]));
            chk($sformatf("dat%0d", c), dout[c*WIDTH +: WIDTH], exp_dat[c]);
        end
        chk("drop_pulse", WIDTH'(drop_pulse), WIDTH'(exp_drop));
`ifdef PRIORITY_DEMUX_REG_DROP_CNT_EN
        chk("drop_cnt", WIDTH'(drop_cnt), WIDTH'(exp_cnt));
`endif
    endtask

    // One clock: apply inputs, check din_rdy, clock, advance model, check outputs.
    task automatic step(input logic [WIDTH-1:0] d, input logic [CNT-1:0] s, input logic v,
                        input logic [CNT-1:0] r, input logic clr);
        logic er, acc, drp;
        int   t;
        din = d; din_sel = s; din_vld = v; dout_rdy = r; drop_cnt_clr = clr;
        #1;
        er = model_rdy(s, r);
        last_rdy = din_rdy;
        chk("din_rdy", WIDTH'(din_rdy), WIDTH'(er));
        @(posedge clk);
        if (rst) begin
            for (int c = 0; c < CNT; c++) begin exp_vld[c] = 1'b0; exp_dat[c] = '0; end
            exp_drop = 1'b0;
            exp_cnt  = 0;
        end else begin
            acc = v && er;
            t   = lowest(s);
            drp = acc && (t < 0);
            for (int c = 0; c < CNT; c++) begin
                if (acc && c == t) begin exp_vld[c] = 1'b1; exp_dat[c] = d; end
                else if (r[c]) exp_vld[c] = 1'b0;
            end
            exp_drop = drp;
            if (clr) exp_cnt = drp ? 1 : 0;
            else if (drp && exp_cnt < 65535) exp_cnt++;
        end
        #1;
        check_outputs();
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        logic [CNT-1:0]   rs, rr;
        logic             rv, hold;

        for (int c = 0; c < CNT; c++) begin exp_vld[c] = 1'b0; exp_dat[c] = '0; end
        exp_drop = 1'b0; exp_cnt = 0; last_rdy = 1'b0;
        din = '0; din_sel = '0; din_vld = 1'b0; dout_rdy = '0; drop_cnt_clr = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();
        chk("rst_vld_all", WIDTH'(dout_vld), '0);

        // Reset mid-traffic
        step(32'hA5A5A5A5, 5'b00001, 1'b1, 5'b00000, 1'b0);
        step(32'hA5A5A5A5, 5'b00100, 1'b1, 5'b00000, 1'b0);
        chk("pre_rst_vld", WIDTH'(dout_vld), WIDTH'(5'b00101));
        rst = 1'b1;
        step(32'h12345678, 5'b00001, 1'b0, 5'b00000, 1'b0);
        rst = 1'b0;
        chk("post_rst_vld", WIDTH'(dout_vld), '0);
        chk("post_rst_dout0", dout[0 +: WIDTH], '0);
        chk("post_rst_dout2", dout[2*WIDTH +: WIDTH], '0);
        for (int i = 0; i < 4; i++) begin
            step('0, CNT'($urandom_range(0, 31)), 1'b0, 5'b00000, 1'b0);
            chk("post_rst_rdy", WIDTH'(last_rdy), 1);
        end

        // Priority decode
        step(32'h11223344, 5'b10110, 1'b1, 5'b11111, 1'b0);
        chk("prio_vld", WIDTH'(dout_vld), WIDTH'(5'b00010));
        chk("prio_dat1", dout[1*WIDTH +: WIDTH], 32'h11223344);

        // Back-pressure isolation
        step(32'h333, 5'b01000, 1'b1, 5'b00000, 1'b0);
        step(32'h444, 5'b01000, 1'b1, 5'b00000, 1'b0);
        chk("bp_blocked_rdy", WIDTH'(last_rdy), 0);
        step(32'h555, 5'b00001, 1'b1, 5'b00000, 1'b0);
        chk("bp_other_rdy", WIDTH'(last_rdy), 1);
        chk("bp_vld0", WIDTH'(dout_vld[0]), 1);
        chk("bp_dat3", dout[3*WIDTH +: WIDTH], 32'h333);
        step('0, '0, 1'b0, 5'b11111, 1'b0);

        // Streaming throughput
        for (int i = 0; i < 8; i++) begin
            step(WIDTH'(i), 5'b10000, 1'b1, 5'b11111, 1'b0);
            chk("stream_rdy", WIDTH'(last_rdy), 1);
            chk("stream_dat4", dout[4*WIDTH +: WIDTH], WIDTH'(i));
            chk("stream_vld4", WIDTH'(dout_vld[4]), 1);
        end
        step('0, '0, 1'b0, 5'b11111, 1'b0);

        // Drain and load on the same cycle
        step(32'hDEAD, 5'b00100, 1'b1, 5'b00000, 1'b0);
        step(32'hBEEF, 5'b00100, 1'b1, 5'b00100, 1'b0);
        chk("dl_in_rdy", WIDTH'(last_rdy), 1);
        chk("dl_vld2", WIDTH'(dout_vld[2]), 1);
        chk("dl_dat2", dout[2*WIDTH +: WIDTH], 32'hBEEF);
        step('0, '0, 1'b0, 5'b00100, 1'b0);
        chk("dl_drained", WIDTH'(dout_vld[2]), 0);
        chk("dl_hold", dout[2*WIDTH +: WIDTH], 32'hBEEF);

        // Drops
        step('0, '0, 1'b0, 5'b00000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(32'hFFFF0000 + WIDTH'(i), 5'b00000, 1'b1, 5'b00000, 1'b0);
            chk("drop_rdy", WIDTH'(last_rdy), 1);
            chk("drop_pulse_on", WIDTH'(drop_pulse), 1);
        end
`ifdef PRIORITY_DEMUX_REG_DROP_CNT_EN
        chk("drop_cnt3", WIDTH'(drop_cnt), 3);
`endif
        step('0, '0, 1'b0, 5'b00000, 1'b0);
        chk("drop_pulse_off", WIDTH'(drop_pulse), 0);

`ifdef PRIORITY_DEMUX_REG_DROP_CNT_EN
        step('0, '0, 1'b0, 5'b00000, 1'b1);
        din_sel = '0; din_vld = 1'b1; drop_cnt_clr = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        din_vld = 1'b0;
        exp_cnt = 65534;
        chk("drop_cnt_fffe", WIDTH'(drop_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) step('0, '0, 1'b1, 5'b00000, 1'b0);
        chk("drop_cnt_sat", WIDTH'(drop_cnt), 32'hFFFF);
        step('0, '0, 1'b1, 5'b00000, 1'b1);
        chk("drop_clr_coinc", WIDTH'(drop_cnt), 1);
`endif

        // Random traffic; a stalled beat keeps its din/din_sel until taken
        hold = 1'b0; rd = '0; rs = '0; rv = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                rd = $urandom;
                rs = ($urandom_range(0, 7) == 0) ? '0 : CNT'($urandom);
                rv = ($urandom_range(0, 3) != 0);
            end
            rr = CNT'($urandom);
            step(rd, rs, rv, rr, ($urandom_range(0, 31) == 0));
            hold = rv && !last_rdy;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
